// File: rtl/rv_decode_pkg.sv
// Shared RV32I(M) decode definitions: opcodes, ALU op codes, memory widths
// and the packed control bundle produced by the decoder.
package rv_decode_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1011,
    ALU_M    = 4'b1100
  } alu_op_e;

  // Branch compare codes share the op field with the ALU codes
  localparam logic [3:0] BR_EQ  = 4'b0000;
  localparam logic [3:0] BR_NE  = 4'b0001;
  localparam logic [3:0] BR_LT  = 4'b0010;
  localparam logic [3:0] BR_GE  = 4'b0011;
  localparam logic [3:0] BR_LTU = 4'b0100;
  localparam logic [3:0] BR_GEU = 4'b0101;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic [3:0]      alu_op;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      mem_width;
    logic            mem_unsigned;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_lui;
    logic            is_auipc;
    logic            is_imm;
    logic            is_m;
    logic            illegal;
  } decoded_t;

  // Base-encoding ALU op for a funct3 (funct7/imm[11:5] == 0)
  function automatic logic [3:0] alu_op_f3(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I(M) instruction decoder producing a decoded_t
// bundle, with illegal-instruction detection and side-effect suppression.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter bit HAS_M = 1'b1
) (
  input  logic [31:0] i_instr,
  output decoded_t    o_dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic        w_ill;
  decoded_t    w_dec;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

  always_comb begin
    w_dec        = '0;
    w_ill        = 1'b0;
    w_dec.rs1    = i_instr[19:15];
    w_dec.rs2    = i_instr[24:20];
    w_dec.rd     = i_instr[11:7];
    w_dec.funct3 = w_f3;
    w_dec.alu_op = ALU_ADD;

    case (w_opcode)
      OP: begin
        w_dec.rs1_used  = 1'b1;
        w_dec.rs2_used  = 1'b1;
        w_dec.reg_write = 1'b1;
        if (w_f7 == F7_BASE) begin
          w_dec.alu_op = alu_op_f3(w_f3);
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'b000)      w_dec.alu_op = ALU_SUB;
          else if (w_f3 == 3'b101) w_dec.alu_op = ALU_SRA;
          else                     w_ill = 1'b1;
        end else if (HAS_M && (w_f7 == F7_MEXT)) begin
          w_dec.alu_op = ALU_M;
          w_dec.is_m   = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      OP_IMM: begin
        w_dec.rs1_used  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.is_imm    = 1'b1;
        w_dec.imm       = w_imm_i;
        w_dec.alu_op    = alu_op_f3(w_f3);
        // Shift-immediates reuse imm[11:5] as a funct7 qualifier
        if (w_f3 == 3'b001 && w_f7 != F7_BASE) w_ill = 1'b1;
        if (w_f3 == 3'b101) begin
          if (w_f7 == F7_ALT)        w_dec.alu_op = ALU_SRA;
          else if (w_f7 != F7_BASE)  w_ill = 1'b1;
        end
      end
      LOAD: begin
        w_dec.rs1_used     = 1'b1;
        w_dec.reg_write    = 1'b1;
        w_dec.mem_read     = 1'b1;
        w_dec.imm          = w_imm_i;
        w_dec.mem_width    = w_f3[1:0];
        w_dec.mem_unsigned = w_f3[2];
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
      end
      STORE: begin
        w_dec.rs1_used  = 1'b1;
        w_dec.rs2_used  = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.imm       = w_imm_s;
        w_dec.mem_width = w_f3[1:0];
        if (w_f3 > 3'b010) w_ill = 1'b1;
      end
      BRANCH: begin
        w_dec.rs1_used  = 1'b1;
        w_dec.rs2_used  = 1'b1;
        w_dec.is_branch = 1'b1;
        w_dec.imm       = w_imm_b;
        case (w_f3)
          3'b000:  w_dec.alu_op = BR_EQ;
          3'b001:  w_dec.alu_op = BR_NE;
          3'b100:  w_dec.alu_op = BR_LT;
          3'b101:  w_dec.alu_op = BR_GE;
          3'b110:  w_dec.alu_op = BR_LTU;
          3'b111:  w_dec.alu_op = BR_GEU;
          default: w_ill = 1'b1;
        endcase
      end
      JAL: begin
        w_dec.reg_write = 1'b1;
        w_dec.is_jal    = 1'b1;
        w_dec.imm       = w_imm_j;
      end
      JALR: begin
        w_dec.rs1_used  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.is_jalr   = 1'b1;
        w_dec.imm       = w_imm_i;
        if (w_f3 != 3'b000) w_ill = 1'b1;
      end
      LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.is_lui    = 1'b1;
        w_dec.imm       = w_imm_u;
      end
      AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.is_auipc  = 1'b1;
        w_dec.imm       = w_imm_u;
      end
      default: w_ill = 1'b1;
    endcase

    if (i_instr[1:0] != 2'b11) w_ill = 1'b1;

    // Illegal ops still flow downstream but must not cause side effects
    if (w_ill) begin
      w_dec.reg_write = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.is_branch = 1'b0;
      w_dec.is_jal    = 1'b0;
      w_dec.is_jalr   = 1'b0;
    end
    w_dec.illegal = w_ill;
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes the incoming instruction and holds it in
// a one- or two-entry output buffer with valid/ready handshakes and flush.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter bit          HAS_M = 1'b1,
  parameter bit          SKID  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic [3:0]      out_alu_op,
  output logic [2:0]      out_funct3,
  output logic [31:0]     out_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [1:0]      out_mem_width,
  output logic            out_mem_unsigned,
  output logic            out_is_branch,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_is_lui,
  output logic            out_is_auipc,
  output logic            out_is_imm,
  output logic            out_is_m,
  output logic            out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  decoded_t        w_dec;
  decoded_t        r_main;
  decoded_t        r_skid;
  logic [PC_W-1:0] r_main_pc;
  logic [PC_W-1:0] r_skid_pc;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_out_valid;
  logic            r_in_ready;
  logic            w_in_acc;
  logic            w_out_acc;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid;

  rv_decode_comb #(.HAS_M(HAS_M)) u_decode (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  // Without the skid entry, ready must look through to the downstream side
  assign in_ready  = SKID ? r_in_ready : (!r_out_valid || out_ready);
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_acc) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_acc && w_out_acc) begin
          w_load_main_in = 1'b1;
        end else if (w_in_acc) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_out_acc) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_acc) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main    <= '0;
      r_main_pc <= '0;
      r_skid    <= '0;
      r_skid_pc <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main    <= w_dec;
        r_main_pc <= in_pc;
      end else if (w_load_main_skid) begin
        r_main    <= r_skid;
        r_main_pc <= r_skid_pc;
      end
      if (w_load_skid) begin
        r_skid    <= w_dec;
        r_skid_pc <= in_pc;
      end
    end
  end

  assign out_valid        = r_out_valid;
  assign out_pc           = r_main_pc;
  assign out_rs1          = r_main.rs1;
  assign out_rs2          = r_main.rs2;
  assign out_rd           = r_main.rd;
  assign out_rs1_used     = r_main.rs1_used;
  assign out_rs2_used     = r_main.rs2_used;
  assign out_alu_op       = r_main.alu_op;
  assign out_funct3       = r_main.funct3;
  assign out_imm          = r_main.imm;
  assign out_reg_write    = r_main.reg_write;
  assign out_mem_read     = r_main.mem_read;
  assign out_mem_write    = r_main.mem_write;
  assign out_mem_width    = r_main.mem_width;
  assign out_mem_unsigned = r_main.mem_unsigned;
  assign out_is_branch    = r_main.is_branch;
  assign out_is_jal       = r_main.is_jal;
  assign out_is_jalr      = r_main.is_jalr;
  assign out_is_lui       = r_main.is_lui;
  assign out_is_auipc     = r_main.is_auipc;
  assign out_is_imm       = r_main.is_imm;
  assign out_is_m         = r_main.is_m;
  assign out_illegal      = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: DUT A (SKID=1, HAS_M=1) and DUT B (SKID=0, HAS_M=0)
// checked against a hand-built expectation table through per-DUT scoreboards.
module tb_decode_stage;

  localparam int unsigned NENT = 12;

  localparam logic [31:0] F_RW    = 32'h2000;
  localparam logic [31:0] F_MR    = 32'h1000;
  localparam logic [31:0] F_MW    = 32'h0800;
  localparam logic [31:0] F_BR    = 32'h0400;
  localparam logic [31:0] F_JAL   = 32'h0200;
  localparam logic [31:0] F_JALR  = 32'h0100;
  localparam logic [31:0] F_LUI   = 32'h0080;
  localparam logic [31:0] F_AUIPC = 32'h0040;
  localparam logic [31:0] F_IMM   = 32'h0020;
  localparam logic [31:0] F_M     = 32'h0010;
  localparam logic [31:0] F_ILL   = 32'h0008;
  localparam logic [31:0] F_RS1   = 32'h0004;
  localparam logic [31:0] F_RS2   = 32'h0002;
  localparam logic [31:0] F_UNS   = 32'h0001;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] pc;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_err = 0;

  logic [31:0] t_instr [NENT];
  logic [31:0] t_imm   [NENT];
  logic [31:0] t_regs  [NENT];
  logic [31:0] t_ctl   [NENT];
  logic [31:0] t_flags [NENT];

  // ---------------- DUT A ----------------
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_out_imm;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
  logic [3:0]  a_out_alu_op;
  logic [2:0]  a_out_funct3;
  logic [1:0]  a_out_mem_width;
  logic        a_rs1_used, a_rs2_used, a_reg_write, a_mem_read, a_mem_write, a_mem_uns;
  logic        a_is_branch, a_is_jal, a_is_jalr, a_is_lui, a_is_auipc, a_is_imm, a_is_m, a_illegal;
  logic [3:0]  a_idx;

  decode_stage #(.PC_W(32), .HAS_M(1'b1), .SKID(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_rd(a_out_rd),
    .out_rs1_used(a_rs1_used), .out_rs2_used(a_rs2_used),
    .out_alu_op(a_out_alu_op), .out_funct3(a_out_funct3), .out_imm(a_out_imm),
    .out_reg_write(a_reg_write), .out_mem_read(a_mem_read), .out_mem_write(a_mem_write),
    .out_mem_width(a_out_mem_width), .out_mem_unsigned(a_mem_uns),
    .out_is_branch(a_is_branch), .out_is_jal(a_is_jal), .out_is_jalr(a_is_jalr),
    .out_is_lui(a_is_lui), .out_is_auipc(a_is_auipc), .out_is_imm(a_is_imm),
    .out_is_m(a_is_m), .out_illegal(a_illegal)
  );

  // ---------------- DUT B ----------------
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_imm;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [3:0]  b_out_alu_op;
  logic [2:0]  b_out_funct3;
  logic [1:0]  b_out_mem_width;
  logic        b_rs1_used, b_rs2_used, b_reg_write, b_mem_read, b_mem_write, b_mem_uns;
  logic        b_is_branch, b_is_jal, b_is_jalr, b_is_lui, b_is_auipc, b_is_imm, b_is_m, b_illegal;
  logic [3:0]  b_idx;

  decode_stage #(.PC_W(32), .HAS_M(1'b0), .SKID(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd),
    .out_rs1_used(b_rs1_used), .out_rs2_used(b_rs2_used),
    .out_alu_op(b_out_alu_op), .out_funct3(b_out_funct3), .out_imm(b_out_imm),
    .out_reg_write(b_reg_write), .out_mem_read(b_mem_read), .out_mem_write(b_mem_write),
    .out_mem_width(b_out_mem_width), .out_mem_unsigned(b_mem_uns),
    .out_is_branch(b_is_branch), .out_is_jal(b_is_jal), .out_is_jalr(b_is_jalr),
    .out_is_lui(b_is_lui), .out_is_auipc(b_is_auipc), .out_is_imm(b_is_imm),
    .out_is_m(b_is_m), .out_illegal(b_illegal)
  );

  logic [31:0] a_regs, a_ctl, a_flags, b_regs, b_ctl, b_flags;
  assign a_regs  = {17'd0, a_out_rd, a_out_rs1, a_out_rs2};
  assign a_ctl   = {23'd0, a_out_alu_op, a_out_funct3, a_out_mem_width};
  assign a_flags = {18'd0, a_reg_write, a_mem_read, a_mem_write, a_is_branch, a_is_jal,
                    a_is_jalr, a_is_lui, a_is_auipc, a_is_imm, a_is_m, a_illegal,
                    a_rs1_used, a_rs2_used, a_mem_uns};
  assign b_regs  = {17'd0, b_out_rd, b_out_rs1, b_out_rs2};
  assign b_ctl   = {23'd0, b_out_alu_op, b_out_funct3, b_out_mem_width};
  assign b_flags = {18'd0, b_reg_write, b_mem_read, b_mem_write, b_is_branch, b_is_jal,
                    b_is_jalr, b_is_lui, b_is_auipc, b_is_imm, b_is_m, b_illegal,
                    b_rs1_used, b_rs2_used, b_mem_uns};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ent(input int i, input logic [31:0] instr, input logic [31:0] imm,
                     input int rd, input int rs1, input int rs2,
                     input int alu, input int f3, input int w, input logic [31:0] flags);
    t_instr[i] = instr;
    t_imm[i]   = imm;
    t_regs[i]  = 32'((rd << 10) | (rs1 << 5) | rs2);
    t_ctl[i]   = 32'((alu << 5) | (f3 << 2) | w);
    t_flags[i] = flags;
  endtask

  task automatic check_obs(input string who, input sb_t e, input bit has_m,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] regs, input logic [31:0] ctl,
                           input logic [31:0] flags);
    logic [31:0] x_ctl, x_flags;
    x_ctl   = t_ctl[e.idx];
    x_flags = t_flags[e.idx];
    // mul without the M extension decodes as an illegal R-type
    if (!has_m && e.idx == 4'd4) begin
      x_ctl   = 32'd0;
      x_flags = F_ILL | F_RS1 | F_RS2;
    end
    chk({who, "_pc"}, pc, e.pc);
    chk($sformatf("%s_imm[%0d]", who, e.idx), imm, t_imm[e.idx]);
    chk($sformatf("%s_regs[%0d]", who, e.idx), regs, t_regs[e.idx]);
    chk($sformatf("%s_ctl[%0d]", who, e.idx), ctl, x_ctl);
    chk($sformatf("%s_flags[%0d]", who, e.idx), flags, x_flags);
  endtask

  // Scoreboards: pop on output transfer, push on input transfer, clear on flush
  sb_t qa[$];
  sb_t qb[$];
  sb_t ea, pa, eb, pb;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_flush) qa.delete();
      else begin
        if (a_out_valid && a_out_ready) begin
          chk("A_out_expected", 32'(qa.size() != 0), 32'd1);
          if (qa.size() != 0) begin
            ea = qa.pop_front();
            check_obs("A", ea, 1'b1, a_out_pc, a_out_imm, a_regs, a_ctl, a_flags);
          end
        end
        if (a_in_valid && a_in_ready) begin
          pa.idx = a_idx;
          pa.pc  = a_in_pc;
          qa.push_back(pa);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_flush) qb.delete();
      else begin
        if (b_out_valid && b_out_ready) begin
          chk("B_out_expected", 32'(qb.size() != 0), 32'd1);
          if (qb.size() != 0) begin
            eb = qb.pop_front();
            check_obs("B", eb, 1'b0, b_out_pc, b_out_imm, b_regs, b_ctl, b_flags);
          end
        end
        if (b_in_valid && b_in_ready) begin
          pb.idx = b_idx;
          pb.pc  = b_in_pc;
          qb.push_back(pb);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int idx, input logic [31:0] pc);
    a_in_valid = 1'b1;
    a_idx      = 4'(idx);
    a_in_instr = t_instr[idx];
    a_in_pc    = pc;
  endtask

  task automatic drive_b(input int idx, input logic [31:0] pc);
    b_in_valid = 1'b1;
    b_idx      = 4'(idx);
    b_in_instr = t_instr[idx];
    b_in_pc    = pc;
  endtask

  logic [31:0] pc_a, pc_b;

  initial begin
    ent(0,  32'hFFF00093, 32'hFFFFFFFF,  1,  0, 31,  0, 0, 0, F_RW | F_IMM | F_RS1);
    ent(1,  32'h0020A423, 32'h00000008,  8,  1,  2,  0, 2, 2, F_MW | F_RS1 | F_RS2);
    ent(2,  32'hFFDFF06F, 32'hFFFFFFFC,  0, 31, 29,  0, 7, 0, F_RW | F_JAL);
    ent(3,  32'h123452B7, 32'h12345000,  5,  8,  3,  0, 5, 0, F_RW | F_LUI);
    ent(4,  32'h022081B3, 32'h00000000,  3,  1,  2, 12, 0, 0, F_RW | F_M | F_RS1 | F_RS2);
    ent(5,  32'h407302B3, 32'h00000000,  5,  6,  7,  1, 0, 0, F_RW | F_RS1 | F_RS2);
    ent(6,  32'h40315093, 32'h00000403,  1,  2,  3,  8, 5, 0, F_RW | F_IMM | F_RS1);
    ent(7,  32'h0020C863, 32'h00000010, 16,  1,  2,  2, 4, 0, F_BR | F_RS1 | F_RS2);
    ent(8,  32'hFFE1D203, 32'hFFFFFFFE,  4,  3, 30,  0, 5, 1, F_RW | F_MR | F_RS1 | F_UNS);
    ent(9,  32'h00000001, 32'h00000000,  0,  0,  0,  0, 0, 0, F_ILL);
    ent(10, 32'h00009067, 32'h00000000,  0,  1,  0,  0, 1, 0, F_ILL | F_RS1);
    ent(11, 32'h00001517, 32'h00001000, 10,  0,  0,  0, 1, 0, F_RW | F_AUIPC);

    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_instr = '0; a_in_pc = '0; a_idx = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_instr = '0; b_in_pc = '0; b_idx = '0;
    step();
    step();
    rst = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    step();
    // Reset state, with out_ready high while empty
    chk("A_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("A_rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("A_rst_pc", a_out_pc, 32'd0);
    chk("A_rst_imm", a_out_imm, 32'd0);
    chk("A_rst_flags", a_flags, 32'd0);
    chk("A_rst_regs", a_regs, 32'd0);
    chk("B_rst_out_valid", 32'(b_out_valid), 32'd0);
    chk("B_rst_in_ready", 32'(b_in_ready), 32'd1);

    // One instruction at a time through both DUTs: latency and decode
    for (int i = 0; i < int'(NENT); i++) begin
      drive_a(i, 32'h1000 + 32'(i * 4));
      drive_b(i, 32'h2000 + 32'(i * 4));
      step();
      chk("A_latency", 32'(a_out_valid), 32'd1);
      chk("B_latency", 32'(b_out_valid), 32'd1);
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      step();
      chk("A_drained", 32'(a_out_valid), 32'd0);
      chk("B_drained", 32'(b_out_valid), 32'd0);
    end

    // Skid fill on A: ready drops after two accepts with output stalled
    a_out_ready = 1'b0;
    drive_a(5, 32'h100);
    step();
    drive_a(6, 32'h104);
    step();
    chk("A_skid_full_ready", 32'(a_in_ready), 32'd0);
    chk("A_skid_head_pc", a_out_pc, 32'h100);
    drive_a(7, 32'h108);
    step();
    chk("A_stall_valid", 32'(a_out_valid), 32'd1);
    chk("A_stall_ready", 32'(a_in_ready), 32'd0);
    chk("A_stall_pc", a_out_pc, 32'h100);
    chk("A_stall_imm", a_out_imm, 32'd0);
    // Flush together with out_ready rising: nothing is emitted
    a_flush = 1'b1;
    a_out_ready = 1'b1;
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    chk("A_flush_valid", 32'(a_out_valid), 32'd0);
    chk("A_flush_ready", 32'(a_in_ready), 32'd1);
    step();
    chk("A_flush_dropped", 32'(a_out_valid), 32'd0);

    // Random handshakes on both DUTs
    pc_a = 32'h4000_0000;
    pc_b = 32'h8000_0000;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) != 0) drive_a(int'($urandom_range(0, NENT - 1)), pc_a);
      else a_in_valid = 1'b0;
      if ($urandom_range(0, 3) != 0) drive_b(int'($urandom_range(0, NENT - 1)), pc_b);
      else b_in_valid = 1'b0;
      pc_a += 32'd4;
      pc_b += 32'd4;
      a_out_ready = ($urandom_range(0, 2) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      a_flush = ($urandom_range(0, 79) == 0);
      b_flush = ($urandom_range(0, 79) == 0);
      step();
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (4) step();
    chk("A_sb_empty", 32'(qa.size()), 32'd0);
    chk("B_sb_empty", 32'(qb.size()), 32'd0);
    chk("A_end_valid", 32'(a_out_valid), 32'd0);
    chk("B_end_valid", 32'(b_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I(M) decode pipeline stage between fetch and issue. Accepts a fetched instruction plus PC over a valid/ready handshake. Emits a fully decoded control bundle one cycle later, with:
- standard-format immediates,
- AUIPC/JAL/JALR distinguished,
- illegal-instruction detection,
- flush support,
- an optional two-entry skid buffer, so the stage sustains one instruction per cycle with a registered `in_ready`.

## Interface
Parameters:
- `PC_W`, 32, width of the PC carried alongside the instruction.
- `HAS_M`, 1, when 1 decodes M-extension ops; when 0 they are illegal.
- `SKID`, 1, when 1 uses a two-entry buffer with registered `in_ready`; when 0 uses a single register with combinational `in_ready`.

Ports:
- `clk`  in  1  clock. One clock domain; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all buffered instructions.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  instruction address.
- `out_valid`  out  1  decoded bundle present.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_pc`  out  PC_W  PC of the decoded instruction.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register fields.
- `out_rs1_used`, `out_rs2_used`  out  1 each  operand read needed.
- `out_alu_op`  out  4  ALU/branch op code (see Operation).
- `out_funct3`  out  3  raw funct3.
- `out_imm`  out  32  sign-extended immediate.
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1 each  side-effect enables.
- `out_mem_width`  out  2  00 byte, 01 half, 10 word.
- `out_mem_unsigned`  out  1  LBU/LHU.
- `out_is_branch`, `out_is_jal`, `out_is_jalr`, `out_is_lui`, `out_is_auipc`, `out_is_imm`, `out_is_m`  out  1 each  class flags.
- `out_illegal`  out  1  instruction not decodable.

## Operation
Transfers:
- A transfer occurs when `valid && ready` on a port.
- Decode is combinational on `in_instr`. The result is registered into the buffer on an accepted input.

ALU op codes:
- ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 1000 (register and immediate forms alike), SLT 1001, SLTU 1011.
- Any M op uses 1100 with `out_is_m=1`; `out_funct3` selects the variant.
- Branches: BEQ 0000, BNE 0001, BLT 0010, BGE 0011, BLTU 0100, BGEU 0101, with `out_is_branch=1`.
- JAL, JALR, LUI and AUIPC output ALU op 0000 plus their class flag.

Immediates (all sign-extended from `instr[31]`):
- I: `[31:20]`.
- S: `{[31:25],[11:7]}`.
- B: `{[31],[7],[30:25],[11:8],0}`.
- U: `{[31:12],12'b0}`.
- J: `{[31],[19:12],[20],[30:21],0}`.
- R-type: 0.

Illegal conditions, any of:
- `instr[1:0]!=11`.
- Unlisted opcode.
- R-type funct7 not in {0000000, 0100000 (funct3 000/101 only), 0000001 (HAS_M=1 only)}.
- Shift-immediate `[31:25]` not 0000000 (0100000 is also allowed for SRAI).
- Load funct3 011/110/111; store funct3 >010; branch funct3 010/011; JALR funct3 != 000.

When illegal, the bundle is still delivered with `out_illegal=1`, and all of the following are forced to 0:
- `out_reg_write`, `out_mem_read`, `out_mem_write`,
- `out_is_branch`, `out_is_jal`, `out_is_jalr`.

Buffer (SKID=1) states:
- EMPTY: `out_valid=0`, `in_ready=1`.
- ONE: main entry valid.
- TWO: main and skid entries valid, `in_ready=0`.

Transitions:
- EMPTY→ONE on input accept.
- ONE→TWO on accept without output accept.
- ONE→EMPTY on output accept without input accept.
- ONE stays ONE when both accept: main is replaced by the new entry.
- TWO→ONE on output accept: skid moves to main.

SKID=0:
- Single entry.
- `in_ready = !out_valid || out_ready`.

Flush and reset:
- `flush` takes priority over any transfer that cycle. The next state is EMPTY and the input presented that cycle is dropped.
- `rst` has the same effect as `flush`. It also forces every output register to 0.

## Timing
- Latency: an input accepted in cycle N appears with `out_valid=1` in N+1.
- Throughput: 1/cycle with `out_ready` held high, for both SKID settings.
- SKID=1: `in_ready` is a register output with no combinational path from `out_ready`.
- `out_valid` and all bundle fields are stable while `out_valid && !out_ready`. Outputs do not glitch between entries.
- Reset values: `out_valid=0`, all bundle outputs 0, `in_ready=1` in the cycle after reset deasserts.
- `out_ready` asserted while empty has no effect.
- Order is strictly FIFO; no instruction is lost or duplicated except by flush or reset.

## Structure
- Shared package `rv_decode_pkg` holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC),
  - the ALU op enum and memory-width constants,
  - a packed `decoded_t` struct for the bundle.
- Combinational sub-module `rv_decode_comb` (instr → `decoded_t`, with an `HAS_M` parameter) performs decode.
- `decode_stage` instantiates `rv_decode_comb` and owns the buffer state machine.

## Test plan
- `0xFFF00093` (addi x1,x0,-1) → after 1 cycle:
  - `out_imm=0xFFFFFFFF`, `out_rd=1`, `out_alu_op=0000`, `out_is_imm=1`, `out_reg_write=1`.
- `0x0020A423` (sw x2,8(x1)) →
  - `out_imm=8`, `out_mem_write=1`, `out_mem_width=10`, `out_reg_write=0`, `out_rs1=1`, `out_rs2=2`.
- `0xFFDFF06F` (jal x0,-4) →
  - `out_imm=0xFFFFFFFC`, `out_is_jal=1`.
- `0x123452B7` (lui x5,0x12345) →
  - `out_imm=0x12345000`, `out_is_lui=1`.
- `0x022081B3` (mul x3,x1,x2) →
  - HAS_M=1: `out_is_m=1`, `out_alu_op=1100`.
  - HAS_M=0: `out_illegal=1`, `out_reg_write=0`.
- Back-to-back stream with `out_ready` low for 3 cycles (SKID=1) → `in_ready` drops after 2 accepts.
- Then `flush` in the same cycle as `out_ready` rises → `out_valid=0` next cycle, nothing emitted.
- Random `in_valid`/`out_ready` (both SKID settings) → output sequence equals input sequence.
